fc_mac_scheduler: RTL and testbench
===================================

# fc_mac_scheduler

Controller that sequences one shared, externally pipelined IEEE-754 multiply-accumulate unit through a fully-connected classifier layer (N features × M classes), then selects the winning class. It generates read addresses for the feature, weight and bias memories, issues MAC operations under a valid/ready handshake, collects the M class scores, and runs an in-order floating-point argmax. It sits between the memory loader and the MAC datapath; the MAC unit and the memories live outside this block.

## Interface
- N, default 3: features per class (≥2)
- M, default 2: number of classes (≥2)
- AW_N = clog2(N), AW_W = clog2(N*M), CLW = max(1, clog2(M)): derived widths
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin one inference (sampled in IDLE only)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, inference complete
- class_idx  out  CLW  index of the maximum score, valid from done until the next start
- err  out  1  sticky: res_valid seen when no result was outstanding; cleared by start or reset
- rd_en  out  1  read strobe for all three memories
- feat_addr  out  AW_N  feature address i
- w_addr  out  AW_W  weight address j*N+i
- b_addr  out  CLW  bias address j
- mac_issue  out  1  MAC operation valid (operands = memory outputs)
- mac_first  out  1  with mac_issue: acc = bias + a*b
- mac_last  out  1  with mac_issue: last term for class j; unit returns the score
- mac_ready  in  1  MAC unit accepts an issue this cycle
- res_valid  in  1  score valid (in class order 0..M-1)
- res_data  in  32  IEEE-754 single score

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: busy=0. On start: clear counters, err, score count, and argmax registers; go to ISSUE.
- ISSUE: two-stage pipeline. Stage 0 = address counter (j outer 0..M-1, i inner 0..N-1); stage 1 = issue register carrying first (i==0) and last (i==N-1). Memories have 1-cycle synchronous read latency and hold their output when rd_en=0.
- Advance condition adv = !s1_valid || mac_ready. rd_en = s0_valid && adv. Addresses and stage-1 flags hold while adv=0.
- mac_issue = s1_valid. The issue completes when mac_issue && mac_ready.
- After address (M-1, N-1) is read, stage 0 empties. When the final issue completes, go to DRAIN.
- DRAIN: wait until M res_valid pulses total have been counted (counting also happens during ISSUE), then go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Argmax, evaluated on each res_valid:
  - score 0 is taken unconditionally.
  - A later score replaces the current maximum only if strictly greater, so ties keep the lower index.
  - Compare is sign-magnitude: +0 and -0 are equal; for two negatives the smaller magnitude wins.
  - A NaN (exp=0xFF, mant≠0) never replaces. A NaN held as the maximum is replaced by any non-NaN.
- start in any state other than IDLE is ignored.
- res_valid in IDLE or DONE, or beyond M results, sets err and is otherwise ignored.
- Reset at any time: state IDLE; busy, done, rd_en, mac_issue, mac_first, mac_last, err = 0; class_idx = 0; all counters 0. An operation interrupted by reset produces no done.

## Timing
- With start sampled in cycle 0 and mac_ready held at 1:
  - busy=1 from cycle 1.
  - rd_en and addresses in cycles 1..N*M.
  - mac_issue in cycles 2..N*M+1.
- Each cycle with mac_ready=0 while mac_issue=1 delays all later issues by exactly one cycle. No issue is dropped or duplicated.
- done is asserted in the cycle after the M-th res_valid is sampled, or after the final issue completes if that is later. class_idx is updated the same cycle as done and holds afterwards.
- Back-to-back inference: start in the done cycle is ignored. The earliest accepted start is the first IDLE cycle.

## Test plan
- N=4, M=3, mac_ready=1; scores 1.0 (0x3F800000), 2.5 (0x40200000), -3.0 (0xC0400000) -> 12 issues; w_addr 0..11; mac_first at i=0 and mac_last at i=3 for each class; done; class_idx=1; err=0.
- Ties and zeros: scores 2.0, 2.0, 1.0 -> class_idx=0; scores -0.0 (0x80000000), +0.0, -1.0 -> class_idx=0.
- All negative: scores -1.0, -0.5 (0xBF000000), -2.0 -> class_idx=1. NaN: scores 0x7FC00000, 0.5, 0x7FC00000 -> class_idx=1.
- Back-pressure: mac_ready=0 for 3 cycles starting at the 5th issue -> issue sequence identical to the unstalled run; done 3 cycles later; addresses held during the stall.
- start pulsed during ISSUE is ignored (single done). res_valid in IDLE -> err=1, then start clears err.
- reset asserted during ISSUE (cycle 6) -> outputs return to reset values next cycle; no done. A fresh start then completes normally.

Source files
------------

// File: rtl/fc_mac_scheduler.sv
// Sequences one shared, externally pipelined FP multiply-accumulate unit through an
// N x M fully-connected layer, collects the M class scores and reports their argmax.
module fc_mac_scheduler #(
  parameter int N = 3,
  parameter int M = 2,
  localparam int AW_N = $clog2(N),
  localparam int AW_W = $clog2(N * M),
  localparam int CLW  = ($clog2(M) > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [CLW-1:0]  class_idx,
  output logic            err,
  output logic            rd_en,
  output logic [AW_N-1:0] feat_addr,
  output logic [AW_W-1:0] w_addr,
  output logic [CLW-1:0]  b_addr,
  output logic            mac_issue,
  output logic            mac_first,
  output logic            mac_last,
  input  logic            mac_ready,
  input  logic            res_valid,
  input  logic [31:0]     res_data
);

  localparam int RCW = $clog2(M + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Strict sign-magnitude "a > b": signed zeros are equal, NaN never wins over a number.
  function automatic logic score_gt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (is_nan(a)) begin
      res = 1'b0;
    end else if (is_nan(b)) begin
      res = 1'b1;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      res = 1'b0;
    end else if (a[31] != b[31]) begin
      res = !a[31];
    end else if (!a[31]) begin
      res = a[30:0] > b[30:0];
    end else begin
      res = a[30:0] < b[30:0];
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_first_q, s1_first_d;
  logic            s1_last_q, s1_last_d;
  logic [AW_N-1:0] i_q, i_d;
  logic [CLW-1:0]  j_q, j_d;
  logic [AW_W-1:0] w_q, w_d;
  logic [RCW-1:0]  cnt_q, cnt_d;
  logic [31:0]     best_q, best_d;
  logic [CLW-1:0]  best_idx_q, best_idx_d;
  logic [CLW-1:0]  class_idx_q, class_idx_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic adv;
  logic res_ok;

  assign adv = !s1_valid_q || mac_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      s0_valid_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      w_q         <= '0;
      cnt_q       <= '0;
      best_q      <= 32'd0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0_valid_q  <= s0_valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      i_q         <= i_d;
      j_q         <= j_d;
      w_q         <= w_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, issue pipeline, score collection and argmax
  always_comb begin
    state_d     = state_q;
    s0_valid_d  = s0_valid_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    i_d         = i_q;
    j_d         = j_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    res_ok = res_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
             (cnt_q != RCW'(M));

    if (res_ok) begin
      cnt_d = cnt_q + RCW'(1);
      if ((cnt_q == '0) || score_gt(res_data, best_q)) begin
        best_d     = res_data;
        best_idx_d = CLW'(cnt_q);
      end else begin
        best_d     = best_q;
      end
    end else if (res_valid) begin
      err_d = 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          s0_valid_d = 1'b1;
          s1_valid_d = 1'b0;
          i_d        = '0;
          j_d        = '0;
          w_d        = '0;
          cnt_d      = '0;
          best_d     = 32'd0;
          best_idx_d = '0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (adv) begin
          s1_valid_d = s0_valid_q;
          s1_first_d = (i_q == '0);
          s1_last_d  = (i_q == AW_N'(N - 1));
          if (s0_valid_q && (i_q == AW_N'(N - 1)) && (j_q == CLW'(M - 1))) begin
            s0_valid_d = 1'b0;
            i_d        = '0;
            j_d        = '0;
            w_d        = '0;
          end else if (s0_valid_q && (i_q == AW_N'(N - 1))) begin
            i_d = '0;
            j_d = j_q + CLW'(1);
            w_d = w_q + AW_W'(1);
          end else if (s0_valid_q) begin
            i_d = i_q + AW_N'(1);
            w_d = w_q + AW_W'(1);
          end else begin
            i_d = i_q;
          end
        end else begin
          s1_valid_d = s1_valid_q;
        end
        // Final issue accepted with the read stage already empty
        if (s1_valid_q && mac_ready && !s0_valid_q) begin
          if (cnt_d == RCW'(M)) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            class_idx_d = best_idx_d;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (cnt_d == RCW'(M)) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          class_idx_d = best_idx_d;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign err       = err_q;
  assign rd_en     = s0_valid_q && adv;
  assign feat_addr = i_q;
  assign w_addr    = w_q;
  assign b_addr    = j_q;
  assign mac_issue = s1_valid_q;
  assign mac_first = s1_valid_q && s1_first_q;
  assign mac_last  = s1_valid_q && s1_last_q;

endmodule

// File: tb/tb_fc_mac_scheduler.sv
// Randomized self-checking bench for fc_mac_scheduler (N=4, M=3) with a memory/MAC
// responder and a key-based argmax reference model.
module tb_fc_mac_scheduler;
  localparam int N = 4, M = 3, AW_N = 2, AW_W = 4, CLW = 2, NM = 12;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, mac_ready = 1'b1, res_valid = 1'b0;
  logic [31:0] res_data = 32'd0;
  logic busy, done, err, rd_en, mac_issue, mac_first, mac_last;
  logic [CLW-1:0]  class_idx, b_addr;
  logic [AW_N-1:0] feat_addr;
  logic [AW_W-1:0] w_addr;

  int total = 0, bad = 0;
  logic [31:0] scores [M];
  int log_t [64];
  int n_iss, n_rd, first_rd, last_rd, first_iss, last_iss, done_cyc, n_stall;
  bit busy0, busy1, err1, rd_in_stall, addr_moved;
  logic [CLW-1:0] cls;
  logic err_done;

  fc_mac_scheduler #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .class_idx(class_idx), .err(err), .rd_en(rd_en), .feat_addr(feat_addr),
    .w_addr(w_addr), .b_addr(b_addr), .mac_issue(mac_issue), .mac_first(mac_first),
    .mac_last(mac_last), .mac_ready(mac_ready), .res_valid(res_valid), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Reference: order floats by an unsigned key, skip NaNs, first maximum wins.
  function automatic logic [32:0] fkey(input logic [31:0] s);
    logic [32:0] mag = {2'b00, s[30:0]};
    return s[31] ? (33'h100000000 - mag) : (33'h100000000 + mag);
  endfunction

  function automatic int ref_argmax();
    int best = -1;
    logic [32:0] bk = 33'd0;
    for (int j = 0; j < M; j++) begin
      if (!((scores[j][30:23] == 8'hFF) && (scores[j][22:0] != 23'd0))) begin
        if (best < 0 || fkey(scores[j]) > bk) begin
          best = j;
          bk = fkey(scores[j]);
        end
      end
    end
    return (best < 0) ? 0 : best;
  endfunction

  function automatic int exp_tuple(input int k);
    int i = k % N;
    return (i << 12) | (k << 4) | ((k / N) << 2) | ((i == 0) ? 2 : 0) | ((i == N - 1) ? 1 : 0);
  endfunction

  function automatic logic [31:0] rand_score(input int j);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      1: v = {1'($urandom_range(0, 1)), 31'd0};
      2: v = {9'h0FF, 23'($urandom_range(1, 8388607))};
      3: v = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
      4: v = (j > 0) ? scores[$urandom_range(0, j - 1)] : 32'h3F800000;
      default: v = ($urandom_range(0, 1) == 0) ? 32'h40000000 : 32'hBF800000;
    endcase
    return v;
  endfunction

  // Runs one inference: memory model, MAC responder with fixed result latency, ready pattern.
  task automatic run(input int lat, input int mode, input int stall_at, input int stall_len,
                     input int start_again_at);
    int pend_due[$];
    logic [31:0] pend_data[$];
    int stall_rem = stall_len;
    logic [AW_N-1:0] mem_f = '0, prev_f = '0;
    logic [AW_W-1:0] mem_w = '0, prev_w = '0;
    logic [CLW-1:0]  mem_b = '0;
    bit prev_stall = 1'b0, r;
    n_iss = 0; n_rd = 0; first_rd = -1; last_rd = -1; first_iss = -1; last_iss = -1;
    done_cyc = -1; n_stall = 0; rd_in_stall = 1'b0; addr_moved = 1'b0; err_done = 1'bx;
    @(negedge clk);
    busy0 = busy; start = 1'b1; mac_ready = 1'b1; res_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == start_again_at);
      if (k == 1) begin busy1 = busy; err1 = err; end
      if (done) begin
        done_cyc = k; cls = class_idx; err_done = err;
        mac_ready = 1'b1; res_valid = 1'b0; start = 1'b0;
        break;
      end
      if (mode == 1 && mac_issue && n_iss == stall_at && stall_rem > 0) begin
        r = 1'b0; stall_rem--;
      end else if (mode == 2) begin
        r = ($urandom_range(0, 3) != 0);
      end else begin
        r = 1'b1;
      end
      mac_ready = r;
      if (pend_due.size() > 0 && pend_due[0] == k) begin
        res_valid = 1'b1; res_data = pend_data.pop_front(); void'(pend_due.pop_front());
      end else begin
        res_valid = 1'b0; res_data = $urandom;
      end
      #1;
      if (prev_stall && (feat_addr !== prev_f || w_addr !== prev_w)) addr_moved = 1'b1;
      prev_stall = mac_issue && !mac_ready; prev_f = feat_addr; prev_w = w_addr;
      if (mac_issue && !mac_ready) begin
        n_stall++;
        if (rd_en) rd_in_stall = 1'b1;
      end
      if (mac_issue && mac_ready) begin
        if (n_iss < 64) log_t[n_iss] = (int'(mem_f) << 12) | (int'(mem_w) << 4) |
            (int'(mem_b) << 2) | (mac_first ? 2 : 0) | (mac_last ? 1 : 0);
        n_iss++;
        if (first_iss < 0) first_iss = k;
        last_iss = k;
        if (mac_last) begin
          pend_due.push_back(k + lat);
          pend_data.push_back((int'(mem_b) < M) ? scores[mem_b] : 32'h7FC00000);
        end
      end
      if (rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        mem_f = feat_addr; mem_w = w_addr; mem_b = b_addr;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n, output int nd, output int nb);
    nd = 0; nb = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({busy, done, rd_en, mac_issue, mac_first, mac_last, err} !== 7'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, done, rd_en, mac_issue, mac_first, mac_last, err}); end
    total++; if (class_idx !== 2'd0) begin bad++; $display("FAIL reset_class: got %0d want 0", class_idx); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rd_en !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b rd_en=%b want 0 0", busy, rd_en); end
  endtask

  task automatic test_basic();
    int nd, nb;
    scores[0] = 32'h3F800000; scores[1] = 32'h40200000; scores[2] = 32'hC0400000;
    run(2, 0, -1, 0, -1);
    total++; if (n_iss !== NM) begin bad++; $display("FAIL basic_issues: got %0d want %0d", n_iss, NM); end
    for (int k = 0; k < NM; k++) begin
      total++; if (log_t[k] !== exp_tuple(k)) begin bad++; $display("FAIL basic_issue%0d: got %h want %h", k, log_t[k], exp_tuple(k)); end
    end
    total++; if (busy0 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL basic_busy: got c0=%b c1=%b want 0 1", busy0, busy1); end
    total++; if (first_rd !== 1 || last_rd !== NM || n_rd !== NM) begin bad++; $display("FAIL basic_rd_window: got %0d..%0d n=%0d want 1..%0d n=%0d", first_rd, last_rd, n_rd, NM, NM); end
    total++; if (first_iss !== 2 || last_iss !== NM + 1) begin bad++; $display("FAIL basic_issue_window: got %0d..%0d want 2..%0d", first_iss, last_iss, NM + 1); end
    total++; if (done_cyc !== NM + 1 + 2 + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, NM + 4); end
    total++; if (cls !== 2'd1) begin bad++; $display("FAIL basic_class: got %0d want 1", cls); end
    total++; if (err_done !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_done); end
    idle_cycles(4, nd, nb);
    total++; if (nd !== 0 || nb !== 0) begin bad++; $display("FAIL basic_after: dones=%0d busy_cycles=%0d want 0 0", nd, nb); end
    total++; if (class_idx !== 2'd1) begin bad++; $display("FAIL basic_class_hold: got %0d want 1", class_idx); end
  endtask

  task automatic test_argmax_cases();
    logic [31:0] tab [4][3] = '{
      '{32'h40000000, 32'h40000000, 32'h3F800000},
      '{32'h80000000, 32'h00000000, 32'hBF800000},
      '{32'hBF800000, 32'hBF000000, 32'hC0000000},
      '{32'h7FC00000, 32'h3F000000, 32'h7FC00000}};
    int want [4] = '{0, 0, 1, 1};
    logic [CLW-1:0] w;
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < M; j++) scores[j] = tab[t][j];
      run($urandom_range(1, 4), 0, -1, 0, -1);
      w = want[t][CLW-1:0];
      total++; if (cls !== w) begin bad++; $display("FAIL argmax_case%0d: got %0d want %0d", t, cls, want[t]); end
      total++; if (int'(cls) !== ref_argmax()) begin bad++; $display("FAIL argmax_model%0d: got %0d want %0d", t, cls, ref_argmax()); end
    end
  endtask

  task automatic test_backpressure();
    int base_log [NM];
    int base_done;
    scores[0] = 32'h3F800000; scores[1] = 32'hC0000000; scores[2] = 32'h40400000;
    run(2, 0, -1, 0, -1);
    for (int k = 0; k < NM; k++) base_log[k] = log_t[k];
    base_done = done_cyc;
    run(2, 1, 4, 3, -1);
    total++; if (n_iss !== NM) begin bad++; $display("FAIL bp_issues: got %0d want %0d", n_iss, NM); end
    for (int k = 0; k < NM; k++) begin
      total++; if (log_t[k] !== base_log[k]) begin bad++; $display("FAIL bp_issue%0d: got %h want %h", k, log_t[k], base_log[k]); end
    end
    total++; if (done_cyc !== base_done + 3) begin bad++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, base_done + 3); end
    total++; if (n_stall !== 3 || rd_in_stall !== 1'b0 || addr_moved !== 1'b0) begin bad++; $display("FAIL bp_hold: stalls=%0d rd=%b moved=%b want 3 0 0", n_stall, rd_in_stall, addr_moved); end
    total++; if (cls !== 2'd2) begin bad++; $display("FAIL bp_class: got %0d want 2", cls); end
  endtask

  task automatic test_start_ignored();
    int nd, nb;
    scores[0] = 32'hC0000000; scores[1] = 32'h3F800000; scores[2] = 32'h3F000000;
    run(2, 0, -1, 0, 4);
    total++; if (done_cyc !== NM + 4) begin bad++; $display("FAIL start_ign_done: got %0d want %0d", done_cyc, NM + 4); end
    idle_cycles(30, nd, nb);
    total++; if (nd !== 0 || nb !== 0) begin bad++; $display("FAIL start_ign_single: extra dones=%0d busy_cycles=%0d want 0 0", nd, nb); end
    total++; if (cls !== 2'd1) begin bad++; $display("FAIL start_ign_class: got %0d want 1", cls); end
  endtask

  task automatic test_back_to_back();
    scores[0] = 32'h3F800000; scores[1] = 32'h3F000000; scores[2] = 32'h3E800000;
    run(3, 0, -1, 0, -1);
    total++; if (cls !== 2'd0) begin bad++; $display("FAIL b2b_first_class: got %0d want 0", cls); end
    start = 1'b1;
    scores[0] = 32'hBF800000; scores[1] = 32'h3F000000; scores[2] = 32'h40800000;
    run(2, 0, -1, 0, -1);
    total++; if (busy0 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL b2b_start_timing: got c0=%b c1=%b want 0 1", busy0, busy1); end
    total++; if (done_cyc !== NM + 4 || cls !== 2'd2) begin bad++; $display("FAIL b2b_second: done=%0d class=%0d want %0d 2", done_cyc, cls, NM + 4); end
  endtask

  task automatic test_err();
    @(negedge clk);
    res_valid = 1'b1; res_data = 32'h3F800000;
    @(negedge clk);
    res_valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err); end
    repeat (2) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    scores[0] = 32'h3F800000; scores[1] = 32'h40000000; scores[2] = 32'h40400000;
    run(1, 0, -1, 0, -1);
    total++; if (err1 !== 1'b0 || err_done !== 1'b0) begin bad++; $display("FAIL err_clear: got %b/%b want 0/0", err1, err_done); end
    total++; if (cls !== 2'd2) begin bad++; $display("FAIL err_run_class: got %0d want 2", cls); end
  endtask

  task automatic test_reset_mid();
    int nd, nb;
    @(negedge clk);
    start = 1'b1; mac_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin @(negedge clk); start = 1'b0; end
    @(negedge clk);
    total++; if (mac_issue !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_active: issue=%b busy=%b want 1 1", mac_issue, busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({busy, done, rd_en, mac_issue, mac_first, mac_last, err, class_idx} !== 9'd0) begin bad++; $display("FAIL rstmid_outputs: got %b want 0", {busy, done, rd_en, mac_issue, mac_first, mac_last, err, class_idx}); end
    idle_cycles(30, nd, nb);
    total++; if (nd !== 0 || nb !== 0) begin bad++; $display("FAIL rstmid_no_done: dones=%0d busy_cycles=%0d want 0 0", nd, nb); end
    scores[0] = 32'h3F000000; scores[1] = 32'h3F800000; scores[2] = 32'h3F400000;
    run(2, 0, -1, 0, -1);
    total++; if (done_cyc !== NM + 4 || cls !== 2'd1) begin bad++; $display("FAIL rstmid_fresh: done=%0d class=%0d want %0d 1", done_cyc, cls, NM + 4); end
  endtask

  task automatic test_random();
    int lat, e;
    logic [CLW-1:0] w;
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < M; j++) scores[j] = rand_score(j);
      lat = $urandom_range(1, 5);
      run(lat, 2, -1, 0, -1);
      e = ref_argmax();
      w = e[CLW-1:0];
      total++; if (n_iss !== NM || n_rd !== NM) begin bad++; $display("FAIL rnd%0d_counts: issues=%0d reads=%0d want %0d", it, n_iss, n_rd, NM); end
      for (int k = 0; k < NM && k < n_iss; k++) begin
        total++; if (log_t[k] !== exp_tuple(k)) begin bad++; $display("FAIL rnd%0d_issue%0d: got %h want %h", it, k, log_t[k], exp_tuple(k)); end
      end
      total++; if (cls !== w) begin bad++; $display("FAIL rnd%0d_class: got %0d want %0d (%h %h %h)", it, cls, e, scores[0], scores[1], scores[2]); end
      total++; if (done_cyc !== last_iss + lat + 1 || err_done !== 1'b0) begin bad++; $display("FAIL rnd%0d_done: cycle=%0d err=%b want %0d 0", it, done_cyc, err_done, last_iss + lat + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_argmax_cases();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
